// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style CPU.
// Contents: opcode values, control-word bit positions (\L_MA at bit 11
// down to \L_O at bit 0), the memory-stage FSM encoding and the default
// memory geometry.
package sap_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Opcodes live in the upper nibble of an instruction word.
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit positions. Most strobes are active low.
    localparam int SIG_MAR_ADDR_LOAD_N = 11;
    localparam int SIG_MAR_MEM_LOAD_N  = 10;
    localparam int SIG_RAM_EN_N        = 9;
    localparam int SIG_RAM_LOAD_N      = 8;
    localparam int SIG_IR_EN_N         = 7;
    localparam int SIG_IR_LOAD_N       = 6;
    localparam int SIG_A_LOAD_N        = 5;
    localparam int SIG_A_EN            = 4;
    localparam int SIG_SUB             = 3;
    localparam int SIG_ALU_EN          = 2;
    localparam int SIG_B_LOAD_N        = 1;
    localparam int SIG_OUT_LOAD_N      = 0;

    // Memory-stage states. MEM_SCRUB is only reachable with MEM_SCRUB_EN.
    typedef enum logic [1:0] {
        MEM_RUN    = 2'd0,
        MEM_PWAIT  = 2'd1,
        MEM_PWRITE = 2'd2,
        MEM_SCRUB  = 2'd3
    } mem_state_e;

endpackage

// File: rtl/sap_ram16x8.sv
// RAM for the SAP memory stage: one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module sap_ram16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sap_memory_unit.sv
// Memory stage of the SAP CPU: MAR, MDR, RAM and a handshaked program
// loader that fills RAM while the CPU is held off.
// Ports: clk, rst (sync, active high); bus_in and the active-low strobes
// mar_addr_load_n / mar_mem_load_n / ram_en_n / ram_load_n from the
// control block; bus_out/bus_oe to the shared bus; the loader port
// prog_mode/prog_valid/prog_addr/prog_data/prog_ready/prog_count;
// mem_busy (high while not in RUN) and mar_q for debug.
// Build option: define MEM_SCRUB_EN to zero the RAM after every reset.
module sap_memory_unit
    import sap_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_addr_load_n,
    input  logic              mar_mem_load_n,
    input  logic              ram_en_n,
    input  logic              ram_load_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic [ADDR_W:0]   prog_count,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] mar_q
);

    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(2**ADDR_W);
`ifdef MEM_SCRUB_EN
    localparam mem_state_e RESET_STATE = MEM_SCRUB;
`else
    localparam mem_state_e RESET_STATE = MEM_RUN;
`endif

    mem_state_e        state_r;
    mem_state_e        state_s;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] mdr_r;
    logic [ADDR_W-1:0] ld_addr_r;
    logic [DATA_W-1:0] ld_data_r;
    logic [ADDR_W:0]   count_r;
    logic              ready_r;
    logic              busy_r;
    logic              cpu_run_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;
`ifdef MEM_SCRUB_EN
    logic [ADDR_W-1:0] scrub_r;
`endif

    // The CPU owns the RAM only in RUN and only while the loader is not asking for it.
    assign cpu_run_s = (state_r == MEM_RUN) && !prog_mode;

    // Next-state logic for the memory FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            MEM_RUN: begin
                if (prog_mode) state_s = MEM_PWAIT;
                else           state_s = MEM_RUN;
            end
            MEM_PWAIT: begin
                // A word offered together with prog_mode falling is still taken.
                if (prog_valid)      state_s = MEM_PWRITE;
                else if (!prog_mode) state_s = MEM_RUN;
                else                 state_s = MEM_PWAIT;
            end
            MEM_PWRITE: begin
                if (prog_mode) state_s = MEM_PWAIT;
                else           state_s = MEM_RUN;
            end
`ifdef MEM_SCRUB_EN
            MEM_SCRUB: begin
                if (scrub_r == '1) state_s = MEM_RUN;
                else               state_s = MEM_SCRUB;
            end
`endif
            default: state_s = RESET_STATE;
        endcase
    end

    // RAM write-port mux: CPU store, loader word or scrub; rst suppresses any write.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = mar_r;
        wdata_s = mdr_r;
        case (state_r)
            MEM_RUN: begin
                we_s = cpu_run_s && !ram_load_n && !rst;
            end
            MEM_PWRITE: begin
                we_s    = !rst;
                waddr_s = ld_addr_r;
                wdata_s = ld_data_r;
            end
`ifdef MEM_SCRUB_EN
            MEM_SCRUB: begin
                we_s    = !rst;
                waddr_s = scrub_r;
                wdata_s = '0;
            end
`endif
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    sap_ram16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (mar_r),
        .rdata (rdata_s)
    );

    // Zero-latency read so the IR can capture the word in the same T-state.
    assign bus_oe  = cpu_run_s && !ram_en_n && !rst;
    assign bus_out = bus_oe ? rdata_s : '0;

    // FSM, MAR/MDR, loader holding registers and the loader word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RESET_STATE;
            mar_r     <= '0;
            mdr_r     <= '0;
            ld_addr_r <= '0;
            ld_data_r <= '0;
            count_r   <= '0;
            ready_r   <= 1'b0;
            busy_r    <= (RESET_STATE != MEM_RUN);
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == MEM_PWAIT);
            busy_r  <= (state_s != MEM_RUN);
            if (cpu_run_s && !mar_addr_load_n) begin
                mar_r <= bus_in[ADDR_W-1:0];
            end
            if (cpu_run_s && !mar_mem_load_n) begin
                mdr_r <= bus_in;
            end
            if ((state_r == MEM_PWAIT) && prog_valid) begin
                ld_addr_r <= prog_addr;
                ld_data_r <= prog_data;
            end
            if ((state_r == MEM_RUN) && prog_mode) begin
                count_r <= '0;
            end else if ((state_r == MEM_PWRITE) && (count_r != COUNT_MAX)) begin
                count_r <= count_r + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef MEM_SCRUB_EN
    // Scrub address: restarts on every reset, advances one word per SCRUB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_r <= '0;
        end else if (state_r == MEM_SCRUB) begin
            scrub_r <= scrub_r + ADDR_W'(1);
        end
    end
`endif

    assign prog_ready = ready_r;
    assign prog_count = count_r;
    assign mem_busy   = busy_r;
    assign mar_q      = mar_r;

endmodule

// File: tb/tb_sap_memory_unit.sv
// Self-checking bench for sap_memory_unit. Inputs change on the falling
// edge (as the control block does); outputs are sampled 2 ns later.
// Expected values go into a scoreboard queue when stimulus is applied and
// are popped against the DUT outputs. Define MEM_SCRUB_EN to cover the
// scrub build.
module tb_sap_memory_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_in;
    logic       mar_addr_load_n;
    logic       mar_mem_load_n;
    logic       ram_en_n;
    logic       ram_load_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       prog_mode;
    logic       prog_valid;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic [4:0] prog_count;
    logic       mem_busy;
    logic [3:0] mar_q;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t   sb_q[$];
    int         n_checks = 0;
    int         n_bad    = 0;
    logic [7:0] ram_m [16];

    sap_memory_unit dut (
        .clk             (clk),
        .rst             (rst),
        .bus_in          (bus_in),
        .mar_addr_load_n (mar_addr_load_n),
        .mar_mem_load_n  (mar_mem_load_n),
        .ram_en_n        (ram_en_n),
        .ram_load_n      (ram_load_n),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .prog_mode       (prog_mode),
        .prog_valid      (prog_valid),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data),
        .prog_ready      (prog_ready),
        .prog_count      (prog_count),
        .mem_busy        (mem_busy),
        .mar_q           (mar_q)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [15:0] got);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_val("sb_depth", 16'(sb_q.size()), 16'd1);
        end else begin
            it = sb_q.pop_front();
            check_val(it.tag, got, it.exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic strobes_idle();
        mar_addr_load_n = 1'b1;
        mar_mem_load_n  = 1'b1;
        ram_en_n        = 1'b1;
        ram_load_n      = 1'b1;
    endtask

    task automatic strobes_random();
        {mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n} = 4'($urandom_range(0, 15));
        bus_in = 8'($urandom_range(0, 255));
    endtask

    // Load MAR with a, then assert \CE and check {bus_oe, bus_out}.
    task automatic read_addr(input logic [3:0] a, input logic [7:0] exp, input string tag);
        strobes_idle();
        mar_addr_load_n = 1'b0;
        bus_in          = {4'h0, a};
        step();
        mar_addr_load_n = 1'b1;
        bus_in          = 8'h00;
        ram_en_n        = 1'b0;
        sb_push(tag, {7'd0, 1'b1, exp});
        #2;
        sb_pop({7'd0, bus_oe, bus_out});
        ram_en_n = 1'b1;
    endtask

    // CPU store: MAR <= a, MDR <= d, RAM[MAR] <= MDR.
    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        strobes_idle();
        mar_addr_load_n = 1'b0;
        bus_in          = {4'h0, a};
        step();
        mar_addr_load_n = 1'b1;
        mar_mem_load_n  = 1'b0;
        bus_in          = d;
        step();
        mar_mem_load_n = 1'b1;
        ram_load_n     = 1'b0;
        step();
        ram_load_n = 1'b1;
        ram_m[a]   = d;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        #2;
        while (mem_busy === 1'b1 && n < budget) begin
            step();
            #2;
            n++;
        end
        sb_push("idle", 16'd0);
        sb_pop(16'(mem_busy));
    endtask

    task automatic count_busy(input int limit, output int n);
        n = 0;
        #2;
        while (mem_busy === 1'b1 && n < limit) begin
            n++;
            step();
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        strobes_idle();
        bus_in     = 8'h00;
        prog_mode  = 1'b0;
        prog_valid = 1'b0;
        prog_addr  = 4'h0;
        prog_data  = 8'h00;
        repeat (3) step();
        #2;
        sb_push("rst_mar", 16'd0);        sb_pop(16'(mar_q));
        sb_push("rst_count", 16'd0);      sb_pop(16'(prog_count));
        sb_push("rst_ready", 16'd0);      sb_pop(16'(prog_ready));
        sb_push("rst_oe", 16'd0);         sb_pop(16'(bus_oe));
`ifdef MEM_SCRUB_EN
        sb_push("rst_busy", 16'd1);       sb_pop(16'(mem_busy));
`else
        sb_push("rst_busy", 16'd0);       sb_pop(16'(mem_busy));
`endif
        step();
        rst = 1'b0;
        wait_idle(40);

        // 1: load 0x4E at address 3 through the loader.
        step();
        prog_mode = 1'b1;
        step();
        #2;
        sb_push("t1_ready_wait", 16'd1);  sb_pop(16'(prog_ready));
        sb_push("t1_busy_wait", 16'd1);   sb_pop(16'(mem_busy));
        sb_push("t1_count_clr", 16'd0);   sb_pop(16'(prog_count));
        prog_valid = 1'b1;
        prog_addr  = 4'h3;
        prog_data  = 8'h4E;
        step();
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        #2;
        sb_push("t1_ready_write", 16'd0); sb_pop(16'(prog_ready));
        sb_push("t1_busy_write", 16'd1);  sb_pop(16'(mem_busy));
        step();
        ram_m[3] = 8'h4E;
        #2;
        sb_push("t1_busy_run", 16'd0);    sb_pop(16'(mem_busy));
        sb_push("t1_count", 16'd1);       sb_pop(16'(prog_count));

        // 2: RUN read of address 3, then \CE released.
        step();
        read_addr(4'h3, ram_m[3], "t2_read");
        #1;
        sb_push("t2_idle_bus", 16'd0);    sb_pop({7'd0, bus_oe, bus_out});
        sb_push("t2_mar", 16'h3);         sb_pop(16'(mar_q));

        // 3: STA path.
        step();
        cpu_write(4'hF, 8'hA5);
        read_addr(4'hF, 8'hA5, "t3_sta");

        // 4: \L_MA and \L_R on the same edge write at the old MAR.
        step();
        cpu_write(4'h2, 8'h77);
        mar_addr_load_n = 1'b0;
        bus_in          = 8'h0F;
        step();
        mar_addr_load_n = 1'b1;
        mar_mem_load_n  = 1'b0;
        bus_in          = 8'h3C;
        step();
        mar_mem_load_n  = 1'b1;
        mar_addr_load_n = 1'b0;
        ram_load_n      = 1'b0;
        bus_in          = 8'h02;
        step();
        strobes_idle();
        ram_m[15] = 8'h3C;
        #2;
        sb_push("t4_mar", 16'h2);         sb_pop(16'(mar_q));
        read_addr(4'h2, ram_m[2], "t4_ram2");
        read_addr(4'hF, ram_m[15], "t4_ramF");

        // 5: 20 loader words with CPU strobes toggling; last word drops prog_mode.
        step();
        strobes_idle();
        prog_mode = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            prog_valid = 1'b1;
            prog_addr  = i[3:0];
            prog_data  = 8'(8'h80 + i);
            if (i == 19) prog_mode = 1'b0;
            strobes_random();
            #2;
            sb_push("t5_ready_wait", 16'd1); sb_pop(16'(prog_ready));
            sb_push("t5_oe_wait", 16'd0);    sb_pop(16'(bus_oe));
            sb_push("t5_mar_wait", 16'hF);   sb_pop(16'(mar_q));
            step();
            strobes_random();
            #2;
            sb_push("t5_ready_write", 16'd0); sb_pop(16'(prog_ready));
            sb_push("t5_oe_write", 16'd0);    sb_pop(16'(bus_oe));
            step();
            ram_m[i % 16] = 8'(8'h80 + i);
            strobes_idle();
            prog_valid = 1'b0;
            #2;
            sb_push("t5_count", 16'((i + 1 > 16) ? 16 : i + 1));
            sb_pop(16'(prog_count));
        end
        sb_push("t5_busy_run", 16'd0);    sb_pop(16'(mem_busy));
        sb_push("t5_mar_kept", 16'hF);    sb_pop(16'(mar_q));
        // MDR must still hold 0x3C: store it and read it back.
        step();
        ram_load_n = 1'b0;
        step();
        ram_load_n = 1'b1;
        ram_m[15]  = 8'h3C;
        for (int a = 0; a < 16; a++) begin
            read_addr(a[3:0], ram_m[a], "t5_ram");
        end

        // rst during PWRITE aborts the write.
        step();
        prog_mode = 1'b1;
        step();
        prog_valid = 1'b1;
        prog_addr  = 4'h5;
        prog_data  = 8'hEE;
        step();
        rst        = 1'b1;
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        step();
        rst = 1'b0;
`ifdef MEM_SCRUB_EN
        for (int a = 0; a < 16; a++) ram_m[a] = 8'h00;
`endif
        wait_idle(40);
        sb_push("t5_rst_count", 16'd0);   sb_pop(16'(prog_count));
        sb_push("t5_rst_mar", 16'd0);     sb_pop(16'(mar_q));
        read_addr(4'h5, ram_m[5], "t5_aborted");

`ifdef MEM_SCRUB_EN
        // 6: scrub window length, restart on rst, RAM zeroed.
        step();
        cpu_write(4'h9, 8'h5A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(40, n);
        sb_push("t6_window", 16'd16);     sb_pop(16'(n));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(7, n);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(40, n);
        sb_push("t6_restart", 16'd16);    sb_pop(16'(n));
        for (int a = 0; a < 16; a++) begin
            read_addr(a[3:0], 8'h00, "t6_zero");
        end
`endif

        step();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
